// File: rtl/fib_pkg.sv
// Shared constants and FSM state type for the two-requester fibonacci scheduler.
package fib_pkg;

  localparam int unsigned FIB_NW = 4;
  localparam int unsigned FIB_FW = 16;
  localparam int unsigned FIB_CW = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_e;

endpackage

// File: rtl/fib_scheduler_fib.sv
// Combinational fibonacci: fib_n_o = fib(n_i), wrapping modulo 2^FW.
module fib_scheduler_fib
  import fib_pkg::*;
#(
  parameter int unsigned NW = FIB_NW,
  parameter int unsigned FW = FIB_FW
) (
  input  logic [NW-1:0] n_i,
  output logic [FW-1:0] fib_n_o
);

  // Unrolled recurrence; each stage advances the (a, b) pair only while k < n.
  always_comb begin
    logic [FW-1:0] a;
    logic [FW-1:0] b;
    logic [FW-1:0] t;
    a = '0;
    b = FW'(1);
    t = '0;
    for (int unsigned k = 0; k < (1 << NW); k++) begin
      if (k < 32'(n_i)) begin
        t = a + b;
        a = b;
        b = t;
      end
    end
    fib_n_o = a;
  end

endmodule

// File: rtl/fib_scheduler.sv
// Round-robin scheduler sharing one fibonacci datapath between two requesters,
// with a registered response held until the consumer accepts it.
module fib_scheduler
  import fib_pkg::*;
#(
  parameter int unsigned NW = FIB_NW,
  parameter int unsigned FW = FIB_FW,
  parameter int unsigned CW = FIB_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_valid,
  input  logic [NW-1:0] req_n0,
  input  logic [NW-1:0] req_n1,
  output logic [1:0]    req_ready,
  output logic          rsp_valid,
  output logic          rsp_id,
  output logic [NW-1:0] rsp_n,
  output logic [FW-1:0] rsp_data,
  input  logic          rsp_ready,
  output logic          busy,
  output logic [CW-1:0] served0,
  output logic [CW-1:0] served1
);

  state_e        state_q, state_d;
  logic          rr_q, rr_d;
  logic          id_q, id_d;
  logic [NW-1:0] n_q, n_d;
  logic [FW-1:0] data_q, data_d;
  logic [CW-1:0] served0_q, served0_d;
  logic [CW-1:0] served1_q, served1_d;
  logic          gnt;
  logic [FW-1:0] fib_n;

  fib_scheduler_fib #(.NW(NW), .FW(FW)) u_fib (
    .n_i     (n_q),
    .fib_n_o (fib_n)
  );

  // A lone requester wins outright; on contention rr_q picks the winner.
  always_comb begin
    case (req_valid)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      default: gnt = rr_q;
    endcase
  end

  assign req_ready = (state_q == IDLE && req_valid[gnt]) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;
  assign rsp_n     = n_q;
  assign rsp_data  = data_q;
  assign served0   = served0_q;
  assign served1   = served1_q;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    n_d       = n_q;
    data_d    = data_q;
    served0_d = served0_q;
    served1_d = served1_q;
    case (state_q)
      IDLE: begin
        if (|(req_valid & req_ready)) begin
          id_d    = gnt;
          n_d     = gnt ? req_n1 : req_n0;
          rr_d    = ~gnt;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        data_d  = fib_n;
        state_d = RESP;
      end
      RESP: begin
        // Counters saturate at all-ones rather than wrapping.
        if (rsp_ready) begin
          state_d = IDLE;
          if (id_q) begin
            if (served1_q != '1) served1_d = served1_q + CW'(1);
          end else begin
            if (served0_q != '1) served0_d = served0_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      id_q      <= 1'b0;
      n_q       <= '0;
      data_q    <= '0;
      served0_q <= '0;
      served1_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
      n_q       <= n_d;
      data_q    <= data_d;
      served0_q <= served0_d;
      served1_q <= served1_d;
    end
  end

endmodule

// File: tb/tb_fib_scheduler.sv
// Self-checking bench for fib_scheduler: directed and randomized transactions
// compared against a table-driven fibonacci and arbitration/serve-count model.
module tb_fib_scheduler;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [3:0]  req_n0;
  logic [3:0]  req_n1;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_id;
  logic [3:0]  rsp_n;
  logic [15:0] rsp_data;
  logic        rsp_ready;
  logic        busy;
  logic [7:0]  served0;
  logic [7:0]  served1;

  int checks = 0;
  int errors = 0;
  int fibTab [0:15];
  int modelRr;
  int modelServed [2];

  fib_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_n0    (req_n0),
    .req_n1    (req_n1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_n     (rsp_n),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy),
    .served0   (served0),
    .served1   (served1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkServed(input string tag);
    checkOutput({tag, "_served0"}, 32'(served0), 32'(modelServed[0]));
    checkOutput({tag, "_served1"}, 32'(served1), 32'(modelServed[1]));
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge, idle again.
  task automatic applyStimulus(input logic [1:0] v, input logic [3:0] a, input logic [3:0] b,
                               input int hold);
    int g;
    logic [3:0] n;
    g = (v == 2'b01) ? 0 : (v == 2'b10) ? 1 : modelRr;
    n = (g == 1) ? b : a;
    req_valid = v;
    req_n0    = a;
    req_n1    = b;
    rsp_ready = 1'b0;
    #1;
    checkOutput("idle_busy", 32'(busy), 0);
    checkOutput("grant", 32'(req_ready), (g == 1) ? 2 : 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b11;
    checkOutput("compute_ready", 32'(req_ready), 0);
    checkOutput("compute_valid", 32'(rsp_valid), 0);
    checkOutput("compute_busy", 32'(busy), 1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("resp_valid", 32'(rsp_valid), 1);
    checkOutput("resp_id", 32'(rsp_id), 32'(g));
    checkOutput("resp_n", 32'(rsp_n), 32'(n));
    checkOutput("resp_data", 32'(rsp_data), 32'(fibTab[n]));
    checkOutput("resp_ready", 32'(req_ready), 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      req_n0 = 4'($urandom);
      req_n1 = 4'($urandom);
      checkOutput("hold_valid", 32'(rsp_valid), 1);
      checkOutput("hold_data", 32'(rsp_data), 32'(fibTab[n]));
      checkOutput("hold_id", 32'(rsp_id), 32'(g));
      checkOutput("hold_ready", 32'(req_ready), 0);
      checkOutput("hold_busy", 32'(busy), 1);
    end
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    @(posedge clk);
    if (modelServed[g] < 255) modelServed[g]++;
    modelRr = 1 - g;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("done_valid", 32'(rsp_valid), 0);
    checkOutput("done_busy", 32'(busy), 0);
    checkServed("done");
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    #2;
    modelRr = 0;
    modelServed[0] = 0;
    modelServed[1] = 0;
    checkOutput("rst_valid", 32'(rsp_valid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_id", 32'(rsp_id), 0);
    checkOutput("rst_n", 32'(rsp_n), 0);
    checkOutput("rst_data", 32'(rsp_data), 0);
    checkServed("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    fibTab[0] = 0;
    fibTab[1] = 1;
    for (int k = 2; k < 16; k++) fibTab[k] = fibTab[k-1] + fibTab[k-2];
    req_n0 = '0;
    req_n1 = '0;

    doReset();

    $display("[TB] single request n=7");
    applyStimulus(2'b01, 4'd7, 4'd0, 0);

    $display("[TB] contention round-robin");
    doReset();
    applyStimulus(2'b11, 4'd10, 4'd15, 0);
    applyStimulus(2'b11, 4'd10, 4'd15, 0);
    applyStimulus(2'b11, 4'd10, 4'd15, 0);

    $display("[TB] withdrawn request leaves pointer alone");
    req_valid = 2'b11;
    #1;
    checkOutput("drop_grant", 32'(req_ready), (modelRr == 1) ? 2 : 1);
    #2;
    req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    checkOutput("drop_busy", 32'(busy), 0);
    applyStimulus(2'b11, 4'd3, 4'd4, 0);

    $display("[TB] rsp_ready ignored while idle");
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("idle_rspready_busy", 32'(busy), 0);
    checkServed("idle_rspready");

    $display("[TB] backpressure and boundaries");
    applyStimulus(2'b01, 4'd5, 4'd0, 10);
    applyStimulus(2'b01, 4'd0, 4'd0, 1);
    applyStimulus(2'b10, 4'd0, 4'd1, 0);
    applyStimulus(2'b10, 4'd0, 4'd0, 0);
    applyStimulus(2'b01, 4'd1, 4'd0, 2);
    applyStimulus(2'b10, 4'd0, 4'd15, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 40; i++) begin
      logic [1:0] v;
      v = 2'($urandom_range(1, 3));
      applyStimulus(v, 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] served1 saturation");
    doReset();
    for (int i = 0; i < 258; i++) applyStimulus(2'b10, 4'($urandom), 4'($urandom), 0);
    checkOutput("sat_served1", 32'(served1), 255);
    checkOutput("sat_served0", 32'(served0), 0);

    $display("[TB] reset during compute and response");
    applyStimulus(2'b01, 4'd6, 4'd0, 0);
    req_valid = 2'b01;
    req_n0 = 4'd9;
    @(posedge clk);
    #2;
    req_valid = 2'b00;
    checkOutput("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(rsp_valid), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_served0", 32'(served0), 0);
    checkOutput("midrst_served1", 32'(served1), 0);
    checkOutput("midrst_data", 32'(rsp_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    modelRr = 0;
    modelServed[0] = 0;
    modelServed[1] = 0;
    req_valid = 2'b10;
    req_n1 = 4'd8;
    @(posedge clk);
    @(posedge clk);
    #2;
    req_valid = 2'b00;
    checkOutput("pre_rst_resp", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("resprst_valid", 32'(rsp_valid), 0);
    checkOutput("resprst_served1", 32'(served1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("postrst_valid", 32'(rsp_valid), 0);
    end
    rsp_ready = 1'b0;
    checkServed("postrst");
    applyStimulus(2'b11, 4'd12, 4'd2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
